// File: rtl/seg7_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl_if
//   Bundles the load handshake and the scan outputs of seg7_scan_ctrl.
//   master : host/display side (drives load, load_data; observes the rest)
//   slave  : the scan controller itself
// Signals
//   load        request to load load_data (taken only while ready=1)
//   load_data   NDIG packed BCD digits, digit 0 in the least significant nibble
//   ready       shadow buffer free
//   digit_bcd   nibble for the shared 7-segment decoder
//   an_n        active-low digit enables
//   frame_tick  one-cycle pulse after each frame boundary
// -----------------------------------------------------------------------------
interface seg7_scan_ctrl_if #(
    parameter int NDIG = 4
);
    logic                  load;
    logic [4*NDIG-1:0]     load_data;
    logic                  ready;
    logic [3:0]            digit_bcd;
    logic [NDIG-1:0]       an_n;
    logic                  frame_tick;

    modport master (
        output load, load_data,
        input  ready, digit_bcd, an_n, frame_tick
    );

    modport slave (
        input  load, load_data,
        output ready, digit_bcd, an_n, frame_tick
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
//   Time-multiplexes NDIG BCD digits onto one shared BCD->7-segment decoder.
//   Each digit slot is DIV cycles: BLANK dead-time cycles with all enables off
//   (the decoder input is already switched to the next digit so it settles),
//   then the remaining cycles with that digit's active-low enable asserted.
//   New values are double buffered: a load fills the shadow buffer and is
//   copied into the displayed buffer only at a frame boundary.
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    seg7_scan_ctrl_if.slave (load, load_data, ready, digit_bcd,
//          an_n, frame_tick)
// Build option
//   SEG7_LEADING_ZERO_BLANK_EN : when defined, a digit i>0 whose value and
//          all more significant digits are 0 keeps its enable off; digit 0
//          is always driven. Slot timing is the same either way.
// -----------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter int NDIG  = 4,
    parameter int DIV   = 50000,
    parameter int BLANK = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_scan_ctrl_if.slave   bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int DW = 4 * NDIG;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DW-1:0]     active_q, active_d;
    logic [DW-1:0]     shadow_q, shadow_d;
    logic              pending_q, pending_d;
    logic              ready_q, ready_d;
    logic [3:0]        digit_bcd_q, digit_bcd_d;
    logic [NDIG-1:0]   an_n_q, an_n_d;
    logic              frame_tick_q, frame_tick_d;

    logic              slot_end_s;
    logic              frame_end_s;
    logic [NDIG-1:0]   keep_s;

    // Which digits may be lit given the currently displayed value.
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    always_comb begin
        logic seen_s;
        seen_s = 1'b0;
        keep_s = {NDIG{1'b1}};
        // Walk from the most significant digit down; a digit stays lit once
        // any digit at or above it is nonzero. Digit 0 is always lit.
        for (int i = NDIG - 1; i >= 0; i--) begin
            if (active_q[4*i +: 4] != 4'd0) begin
                seen_s = 1'b1;
            end else begin
                seen_s = seen_s;
            end
            keep_s[i] = seen_s | (i == 0);
        end
    end
`else
    always_comb begin
        keep_s = {NDIG{1'b1}};
    end
`endif

    // Next-state logic for the scan timing, FSM, buffers and output registers.
    always_comb begin
        slot_end_s  = (cnt_q == CW'(DIV - 1));
        frame_end_s = slot_end_s && (idx_q == IW'(NDIG - 1));

        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        active_d     = active_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        ready_d      = ready_q;
        an_n_d       = {NDIG{1'b1}};
        digit_bcd_d  = active_q[{idx_q, 2'b00} +: 4];
        frame_tick_d = frame_end_s;

        // Slot counter and digit index; free running, never stalled by loads.
        if (slot_end_s) begin
            cnt_d = {CW{1'b0}};
            if (idx_q == IW'(NDIG - 1)) begin
                idx_d = {IW{1'b0}};
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
            idx_d = idx_q;
        end

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == CW'(BLANK - 1)) begin
                    state_d = ST_DRIVE;
                end else begin
                    state_d = ST_BLANK;
                end
            end
            ST_DRIVE: begin
                if (slot_end_s) begin
                    state_d = ST_BLANK;
                end else begin
                    state_d = ST_DRIVE;
                end
            end
            default: begin
                state_d = ST_BLANK;
            end
        endcase

        // Enable is a registered copy of the current state, so it lags the
        // state/index by one cycle just like digit_bcd.
        if ((state_q == ST_DRIVE) && keep_s[idx_q]) begin
            an_n_d[idx_q] = 1'b0;
        end else begin
            an_n_d = {NDIG{1'b1}};
        end

        // Commit is evaluated before the load so that a load accepted on the
        // boundary cycle waits for the following boundary.
        if (frame_end_s && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
            ready_d   = 1'b1;
        end else begin
            active_d  = active_q;
        end

        if (bus.load && ready_q) begin
            shadow_d  = bus.load_data;
            pending_d = 1'b1;
            ready_d   = 1'b0;
        end else begin
            shadow_d  = shadow_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BLANK;
            cnt_q        <= {CW{1'b0}};
            idx_q        <= {IW{1'b0}};
            active_q     <= {DW{1'b0}};
            shadow_q     <= {DW{1'b0}};
            pending_q    <= 1'b0;
            ready_q      <= 1'b1;
            digit_bcd_q  <= 4'd0;
            an_n_q       <= {NDIG{1'b1}};
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            ready_q      <= ready_d;
            digit_bcd_q  <= digit_bcd_d;
            an_n_q       <= an_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.ready      = ready_q;
    assign bus.digit_bcd  = digit_bcd_q;
    assign bus.an_n       = an_n_q;
    assign bus.frame_tick = frame_tick_q;
endmodule
